// File: rtl/alu181_chk_pkg.sv
// Shared types and the 74S181 golden function model for the sweep checker.
// The model follows the active-high datasheet function table.
package alu181_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int VEC_W = 14;
    localparam logic [VEC_W-1:0] LAST_VEC = 14'h3FFF;

    typedef struct packed {
        logic [3:0] f;
        logic       x;
        logic       y;
        logic       cout_n;
        logic       aeb;
    } alu_resp_t;

    function automatic alu_resp_t alu181_golden(
        input logic [3:0] s,
        input logic       m,
        input logic       cin_n,
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] h;
        logic [4:0] c;
        alu_resp_t  r;
        // The slice adds p + g + carry; g is always a subset of p.
        p = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        g = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        h = p & ~g;
        c[0] = ~cin_n;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        r.f = m ? ~h : (h ^ c[3:0]);
        r.x = ~(&p);
        r.y = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]));
        r.cout_n = ~c[4];
        r.aeb = &r.f;
        return r;
    endfunction

endpackage

// File: rtl/alu181_golden_ref.sv
// Combinational 74S181 reference built on the package golden function.
// Usable on its own as a drop-in behavioural slice.
module alu181_golden_ref
    import alu181_chk_pkg::*;
(
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] f,
    output logic       x,
    output logic       y,
    output logic       cout_n,
    output logic       aeb
);

    alu_resp_t r;

    assign r = alu181_golden(s, m, cin_n, a, b);
    assign {f, x, y, cout_n, aeb} = r;

endmodule

// File: rtl/alu181_sweep_checker.sv
// Exhaustive sweep exerciser and checker for a 74S181-compatible slice.
// Define ALU181_CHK_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module alu181_sweep_checker
    import alu181_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       s,
    output logic             m,
    output logic             cin_n,
    output logic [3:0]       a,
    output logic [3:0]       b,
    input  logic [3:0]       f,
    input  logic             x,
    input  logic             y,
    input  logic             cout_n,
    input  logic             aeb,
    output logic [ERR_W-1:0] err_count,
    output logic             fail,
    output logic [VEC_W-1:0] fail_vec
);

    localparam int CNT_W = 4;

    state_t           state;
    state_t           state_n;
    logic [VEC_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       gold_f;
    logic             gold_x;
    logic             gold_y;
    logic             gold_cout_n;
    logic             gold_aeb;
    logic             mismatch;
    logic             last;

    alu181_golden_ref u_gold (
        .s      (s),
        .m      (m),
        .cin_n  (cin_n),
        .a      (a),
        .b      (b),
        .f      (gold_f),
        .x      (gold_x),
        .y      (gold_y),
        .cout_n (gold_cout_n),
        .aeb    (gold_aeb)
    );

    // Case inequality so X/Z on the slice outputs is caught in simulation.
    assign mismatch = ({f, x, y, cout_n, aeb}
                   !== {gold_f, gold_x, gold_y, gold_cout_n, gold_aeb});
    assign last = (idx == LAST_VEC);

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = DRIVE;
            end
            DRIVE: begin
                busy    = 1'b1;
                state_n = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (cnt == '0) state_n = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
`ifdef ALU181_CHK_STOP_ON_FAIL_EN
                state_n = (last || mismatch) ? DONE : DRIVE;
`else
                state_n = last ? DONE : DRIVE;
`endif
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            s         <= '0;
            m         <= 1'b0;
            cin_n     <= 1'b1;
            a         <= '0;
            b         <= '0;
            err_count <= '0;
            fail      <= 1'b0;
            fail_vec  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        err_count <= '0;
                        fail      <= 1'b0;
                        fail_vec  <= '0;
                    end
                end
                DRIVE: begin
                    {m, cin_n, s, a, b} <= idx;
                    cnt <= CNT_W'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + ERR_W'(1);
                        if (!fail) begin
                            fail     <= 1'b1;
                            fail_vec <= idx;
                        end
                    end
`ifdef ALU181_CHK_STOP_ON_FAIL_EN
                    if (!last && !mismatch) idx <= idx + 14'd1;
`else
                    if (!last) idx <= idx + 14'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu181_sweep_checker.sv
// Bench for alu181_sweep_checker: behavioural slice with fault injection
// and a scoreboard of expected results compared when results appear.
module tb_alu181_sweep_checker;

    localparam int          SETTLE = 2;
    localparam logic [13:0] WLO    = 14'h2A50;
    localparam logic [13:0] WHI    = 14'h2B4F;
    localparam int          LIMIT  = 70000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done;
    logic [3:0]  s, a, b, f;
    logic        m, cin_n, x, y, cout_n, aeb;
    logic [15:0] err_count;
    logic        fail;
    logic [13:0] fail_vec;

    logic [3:0]  gs, ga, gb, gf;
    logic        gm, gcin, gx, gy, gco, gaeb;

    int          fault_mode;
    logic [7:0]  dut_r;
    logic [13:0] drv_idx;

    int n_chk;
    int n_fail;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu181_sweep_checker #(
        .SETTLE_CYCLES (SETTLE),
        .ERR_W         (16)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .m         (m),
        .cin_n     (cin_n),
        .a         (a),
        .b         (b),
        .f         (f),
        .x         (x),
        .y         (y),
        .cout_n    (cout_n),
        .aeb       (aeb),
        .err_count (err_count),
        .fail      (fail),
        .fail_vec  (fail_vec)
    );

    alu181_golden_ref u_ref (
        .s      (gs),
        .m      (gm),
        .cin_n  (gcin),
        .a      (ga),
        .b      (gb),
        .f      (gf),
        .x      (gx),
        .y      (gy),
        .cout_n (gco),
        .aeb    (gaeb)
    );

    // Datasheet table: arithmetic is (opx + opy + carry), logic is listed.
    function automatic logic [7:0] ref181(
        input logic [3:0] fs,
        input logic       fm,
        input logic       fcn,
        input logic [3:0] fa,
        input logic [3:0] fb
    );
        logic [3:0] opx, opy, fo, lg;
        logic [4:0] sum, gen;
        case (fs)
            4'd0:  begin opx = fa;        opy = 4'h0;      lg = ~fa;          end
            4'd1:  begin opx = fa | fb;   opy = 4'h0;      lg = ~(fa | fb);   end
            4'd2:  begin opx = fa | ~fb;  opy = 4'h0;      lg = ~fa & fb;     end
            4'd3:  begin opx = 4'hF;      opy = 4'h0;      lg = 4'h0;         end
            4'd4:  begin opx = fa;        opy = fa & ~fb;  lg = ~(fa & fb);   end
            4'd5:  begin opx = fa | fb;   opy = fa & ~fb;  lg = ~fb;          end
            4'd6:  begin opx = fa | ~fb;  opy = fa & ~fb;  lg = fa ^ fb;      end
            4'd7:  begin opx = 4'hF;      opy = fa & ~fb;  lg = fa & ~fb;     end
            4'd8:  begin opx = fa;        opy = fa & fb;   lg = ~fa | fb;     end
            4'd9:  begin opx = fa | fb;   opy = fa & fb;   lg = ~(fa ^ fb);   end
            4'd10: begin opx = fa | ~fb;  opy = fa & fb;   lg = fb;           end
            4'd11: begin opx = 4'hF;      opy = fa & fb;   lg = fa & fb;      end
            4'd12: begin opx = fa;        opy = fa;        lg = 4'hF;         end
            4'd13: begin opx = fa | fb;   opy = fa;        lg = fa | ~fb;     end
            4'd14: begin opx = fa | ~fb;  opy = fa;        lg = fa | fb;      end
            default: begin opx = 4'hF;    opy = fa;        lg = fa;           end
        endcase
        sum = {1'b0, opx} + {1'b0, opy} + {4'b0, ~fcn};
        gen = {1'b0, opx} + {1'b0, opy};
        fo  = fm ? lg : sum[3:0];
        return {fo, ~(&(opx | opy)), ~gen[4], ~sum[4], &fo};
    endfunction

    assign drv_idx = {m, cin_n, s, a, b};

    always_comb begin
        dut_r = ref181(s, m, cin_n, a, b);
        if (fault_mode == 1 ||
            (fault_mode == 2 && drv_idx >= WLO && drv_idx <= WHI))
            dut_r[4] = 1'b0;
    end

    assign {f, x, y, cout_n, aeb} = dut_r;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.v);
        end
    endtask

    task automatic run_sweep(output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        while (cyc < LIMIT) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        int          nerr;
        logic [13:0] first;
        logic [13:0] v;
        logic [7:0]  r;
        bit          found;

        n_chk      = 0;
        n_fail     = 0;
        fault_mode = 0;
        start      = 1'b0;
        reset_n    = 1'b0;
        {gs, gm, gcin, ga, gb} = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cin_n", 32'(cin_n), 32'd1);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_mab", 32'({m, a, b}), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_fvec", 32'(fail_vec), 32'd0);
        reset_n = 1'b1;

        gm = 1'b0; gs = 4'b0000; ga = 4'hF; gb = 4'h0; gcin = 1'b1;
        push("spot_add0_f", 32'hF);
        push("spot_add0_aeb", 32'd1);
        #1 pop_chk(32'(gf));
        pop_chk(32'(gaeb));
        gm = 1'b1;
        push("spot_not_a", 32'h0);
        #1 pop_chk(32'(gf));
        gm = 1'b0; gs = 4'b1001; gb = 4'h1;
        push("spot_sum_f", 32'h0);
        push("spot_sum_co", 32'd0);
        #1 pop_chk(32'(gf));
        pop_chk(32'(gco));
        for (int i = 0; i < 8; i++) begin
            {gm, gcin, gs, ga, gb} = 14'($urandom);
            push("spot_rand", 32'(ref181(gs, gm, gcin, ga, gb)));
            #1 pop_chk(32'({gf, gx, gy, gco, gaeb}));
        end

        // Abort a faulty sweep partway; no results may survive reset.
        fault_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (999) @(posedge clk);
        @(negedge clk);
`ifdef ALU181_CHK_STOP_ON_FAIL_EN
        chk("abort_pre_busy", 32'(busy), 32'd0);
`else
        chk("abort_pre_busy", 32'(busy), 32'd1);
`endif
        chk("abort_pre_fail", 32'(fail), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err", 32'(err_count), 32'd0);
        chk("abort_fail", 32'(fail), 32'd0);
        chk("abort_fvec", 32'(fail_vec), 32'd0);
        chk("abort_drv", 32'(drv_idx), 32'h1000);
        @(negedge clk);
        reset_n = 1'b1;
        fault_mode = 2;

        nerr  = 0;
        first = '0;
        found = 1'b0;
        for (int i = int'(WLO); i <= int'(WHI); i++) begin
            v = 14'(i);
            r = ref181(v[11:8], v[13], v[12], v[7:4], v[3:0]);
            if (r[4]) begin
                nerr++;
                if (!found) first = v;
                found = 1'b1;
            end
        end
        push("sw_done_seen", 32'd1);
`ifdef ALU181_CHK_STOP_ON_FAIL_EN
        push("sw_cycles", 32'(4 * int'(first) + 5));
        push("sw_err", 32'd1);
        push("sw_drv", 32'(first));
`else
        push("sw_cycles", 32'(4 * 16384 + 1));
        push("sw_err", 32'(nerr));
        push("sw_drv", 32'h3FFF);
`endif
        push("sw_fail", 32'd1);
        push("sw_fvec", 32'(first));
        push("sw_busy", 32'd0);

        run_sweep(cyc);
        pop_chk(32'(done));
        pop_chk(32'(cyc));
        pop_chk(32'(err_count));
        pop_chk(32'(drv_idx));
        pop_chk(32'(fail));
        pop_chk(32'(fail_vec));
        pop_chk(32'(busy));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu181_sweep_checker.md
Name: alu181_sweep_checker

Overview:
- Self-checking exerciser for any part_74S181-compatible ALU slice, gate-level or behavioural.
- Drives the slice's S/M/CIN_N/A/B inputs through an exhaustive sweep, waits a settle interval, then samples F/X/Y/COUT_N/AEB against a golden 74S181 function model.
- Reports the mismatch count and the first failing vector.
- Sits beside a chip model or board-level ALU in hardware bring-up and simulation benches; it is the response/check end of the chip-stimulus interface.

Parameters:
- SETTLE_CYCLES, 2: clock cycles between driving a vector and sampling the response, 1..15.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes
- s  out  4  function select to DUT {S3..S0}
- m  out  1  mode to DUT, 1 = logic
- cin_n  out  1  carry-in to DUT, active low
- a  out  4  operand A to DUT
- b  out  4  operand B to DUT
- f  in  4  DUT F3..F0
- x  in  1  DUT X (carry propagate, active low)
- y  in  1  DUT Y (carry generate, active low)
- cout_n  in  1  DUT carry-out, active low
- aeb  in  1  DUT A=B output
- err_count  out  ERR_W  mismatching vectors this sweep, saturating
- fail  out  1  sticky; set on first mismatch, cleared by start
- fail_vec  out  14  index {m,cin_n,s,a,b} of the first mismatch

Behaviour:
- Reset (async, reset_n=0) sets all outputs to:
  - busy=0, done=0, s=0, m=0, cin_n=1, a=0, b=0
  - err_count=0, fail=0, fail_vec=0
  - FSM in IDLE, vector index=0
- Vector index: 14-bit idx = {m, cin_n, s[3:0], a[3:0], b[3:0]}; b is the LSBs and the fastest-changing field.
- Sweep order: 0..16383. Drive cin_n = idx[12], so cin_n=0 is covered first.
- FSM states:
  - IDLE: start=1 -> DRIVE; clears err_count, fail, fail_vec; sets idx=0 and busy=1.
  - DRIVE: register outputs from idx, load settle counter = SETTLE_CYCLES-1 -> SETTLE.
  - SETTLE: decrement counter; at 0 -> CHECK.
  - CHECK: compare DUT outputs with golden. On mismatch:
    - increment err_count, saturating at all-ones;
    - if fail=0, set fail and capture fail_vec=idx.
    - Then: idx==16383 -> DONE; otherwise idx+1 -> DRIVE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Throughput: SETTLE_CYCLES+2 cycles per vector.
- DUT drive outputs hold their last vector after DONE until the next sweep.
- Golden model: datasheet 74S181 active-high function table.
  - M=1: F is the logic function of A,B. X, Y and COUT_N are still checked, because the DUT computes them independently of M.
  - M=0: F is the arithmetic function plus carry, with carry = ~cin_n; COUT_N = ~carry-out of the 4-bit sum.
  - X = ~P_group, Y = ~G_group, AEB = (F==4'b1111).
- start while busy is ignored. start held high in IDLE after DONE starts a new sweep on the next cycle.
- reset_n asserted mid-sweep aborts immediately to reset values; no partial results are retained.
- X/Z on a DUT input counts as a mismatch, using case-inequality compare in simulation.

Optional Feature:
- Macro: ALU181_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE. idx, drive outputs and fail_vec are frozen; err_count=1.
- Undefined: the sweep always runs all 16384 vectors.

Decomposition:
- Package alu181_chk_pkg:
  - state enum {IDLE, DRIVE, SETTLE, CHECK, DONE}
  - VEC_W=14, LAST_VEC=14'h3FFF
  - golden-model function alu181_golden(s,m,cin_n,a,b) returning {f,x,y,cout_n,aeb}
- Sub-module alu181_golden_ref: purely combinational wrapper around that function, so the bench can reuse it standalone.

Test Plan:
1. Reset with reset_n=0 for 3 cycles -> busy=0, done=0, cin_n=1, s=0, err_count=0, fail=0.
2. Correct part_74S181 DUT, SETTLE_CYCLES=2, pulse start -> done pulses after 16384*4+1 cycles; err_count=0, fail=0.
3. Spot vectors through golden_ref, each with A=4'b1111, B=0, cin_n=1:
   - M=0, S=0000 -> F=1111, AEB=1.
   - M=1, S=0000 -> F=0000.
   - M=0, S=1001, A=1111, B=0001 -> F=0000, cout_n=0.
4. DUT with F0 stuck at 0 -> fail=1, fail_vec=first idx whose golden F0=1, err_count=number of such vectors.
5. reset_n pulsed low at cycle 1000 of a sweep -> all outputs at reset values; a new start completes normally.
6. With ALU181_CHK_STOP_ON_FAIL_EN and a stuck-F0 DUT -> done at the first failing vector; err_count=1, drive outputs equal fail_vec fields.
